// File: rtl/note_player.sv
// Note sequencer: loads a note and its duration, looks up the phase step, and gates
// sample strobes to the sine reader until the duration has counted down on beat ticks.

module frequency_rom #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 20
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dout
);

   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] semitone;
   logic [ADDR_W-1:0] octave;
   logic [11:0]       base;
   logic [31:0]       wide;
   logic [DATA_W-1:0] dout_d;

   // Note 1 is A1 (55 Hz); each group of 12 semitones is one octave, so the base step doubles.
   always_comb begin
      idx      = addr - ADDR_W'(1);
      semitone = idx % ADDR_W'(12);
      octave   = idx / ADDR_W'(12);
      case (semitone)
         ADDR_W'(0):  base = 12'd1201;
         ADDR_W'(1):  base = 12'd1273;
         ADDR_W'(2):  base = 12'd1349;
         ADDR_W'(3):  base = 12'd1429;
         ADDR_W'(4):  base = 12'd1514;
         ADDR_W'(5):  base = 12'd1604;
         ADDR_W'(6):  base = 12'd1699;
         ADDR_W'(7):  base = 12'd1800;
         ADDR_W'(8):  base = 12'd1907;
         ADDR_W'(9):  base = 12'd2021;
         ADDR_W'(10): base = 12'd2141;
         ADDR_W'(11): base = 12'd2268;
         default:     base = 12'd0;
      endcase
      wide   = 32'(base) << octave;
      dout_d = (addr == '0) ? '0 : DATA_W'(wide);
   end

   always_ff @(posedge clk) begin
      dout <= dout_d;
   end

endmodule

module note_player #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int STEP_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic [NOTE_W-1:0] note_to_load,
   input  logic [DUR_W-1:0]  duration_to_load,
   input  logic              load_new_note,
   input  logic              beat,
   input  logic              sample_tick,
   output logic [STEP_W-1:0] step_size,
   output logic              generate_next_sample,
   output logic              phase_reset,
   output logic              busy,
   output logic              note_done
);

   typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

   state_t            state_q, state_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  cnt_q, cnt_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              gen_q, gen_d;
   logic              phase_reset_q, phase_reset_d;
   logic              busy_q, busy_d;
   logic              note_done_q, note_done_d;
   logic [STEP_W-1:0] rom_dout;

   // The ROM is addressed straight from the input, so its registered output is ready in FETCH.
   frequency_rom #(.ADDR_W(NOTE_W), .DATA_W(STEP_W)) u_rom (
      .clk  (clk),
      .addr (note_to_load),
      .dout (rom_dout)
   );

   always_comb begin
      state_d       = state_q;
      note_d        = note_q;
      cnt_d         = cnt_q;
      step_d        = step_q;
      busy_d        = busy_q;
      phase_reset_d = 1'b0;
      note_done_d   = 1'b0;
      gen_d         = sample_tick && play_enable && (state_q == PLAY);
      case (state_q)
         IDLE: begin
            if (load_new_note) begin
               note_d        = note_to_load;
               cnt_d         = duration_to_load;
               busy_d        = 1'b1;
               phase_reset_d = 1'b1;
               state_d       = FETCH;
            end
         end
         FETCH: begin
            step_d  = (note_q == '0) ? '0 : rom_dout;
            state_d = PLAY;
         end
         PLAY: begin
            // A zero-length note finishes without waiting for a beat.
            if (cnt_q == '0) begin
               state_d     = DONE;
               note_done_d = 1'b1;
            end else if (beat && play_enable) begin
               cnt_d = cnt_q - DUR_W'(1);
               if (cnt_q == DUR_W'(1)) begin
                  state_d     = DONE;
                  note_done_d = 1'b1;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         note_q        <= '0;
         cnt_q         <= '0;
         step_q        <= '0;
         gen_q         <= 1'b0;
         phase_reset_q <= 1'b0;
         busy_q        <= 1'b0;
         note_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         note_q        <= note_d;
         cnt_q         <= cnt_d;
         step_q        <= step_d;
         gen_q         <= gen_d;
         phase_reset_q <= phase_reset_d;
         busy_q        <= busy_d;
         note_done_q   <= note_done_d;
      end
   end

   assign step_size            = step_q;
   assign generate_next_sample = gen_q;
   assign phase_reset          = phase_reset_q;
   assign busy                 = busy_q;
   assign note_done            = note_done_q;

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player; expected step sizes are hand-computed
// from the A1-based semitone table (note 5 -> 1514, note 10 -> 2021, note 20 -> 3600).

module tb_note_player;

   logic        clk;
   logic        reset;
   logic        playEnable;
   logic [5:0]  noteToLoad;
   logic [5:0]  durationToLoad;
   logic        loadNewNote;
   logic        beat;
   logic        sampleTick;
   logic [19:0] stepSize;
   logic        generateNextSample;
   logic        phaseReset;
   logic        busy;
   logic        noteDone;

   int checks = 0;
   int errors = 0;
   int ndCount = 0;
   int gnsCount = 0;
   int gnsSnap = 0;

   note_player #(.NOTE_W(6), .DUR_W(6), .STEP_W(20)) dut (
      .clk                  (clk),
      .reset                (reset),
      .play_enable          (playEnable),
      .note_to_load         (noteToLoad),
      .duration_to_load     (durationToLoad),
      .load_new_note        (loadNewNote),
      .beat                 (beat),
      .sample_tick          (sampleTick),
      .step_size            (stepSize),
      .generate_next_sample (generateNextSample),
      .phase_reset          (phaseReset),
      .busy                 (busy),
      .note_done            (noteDone)
   );

   // 10 ns clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (noteDone === 1'b1) ndCount++;
      if (generateNextSample === 1'b1) gnsCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of load/beat inputs, advance past the next rising edge, then clear the pulses
   task automatic applyStimulus(input logic ld, input logic [5:0] note, input logic [5:0] dur, input logic bt);
      loadNewNote    = ld;
      noteToLoad     = note;
      durationToLoad = dur;
      beat           = bt;
      @(posedge clk);
      #1;
      loadNewNote = 1'b0;
      beat        = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'd0, 6'd0, 1'b0);
   endtask

   // One beat every 8 cycles
   task automatic runBeats(input int n);
      for (int i = 0; i < n; i++) begin
         idleCycles(7);
         applyStimulus(1'b0, 6'd0, 6'd0, 1'b1);
      end
   endtask

   initial begin
      reset = 1'b1;
      playEnable = 1'b0;
      noteToLoad = '0;
      durationToLoad = '0;
      loadNewNote = 1'b0;
      beat = 1'b0;
      sampleTick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstStep", 32'(stepSize), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstDone", 32'(noteDone), 0);
      checkOutput("rstPhase", 32'(phaseReset), 0);
      checkOutput("rstGen", 32'(generateNextSample), 0);
      reset = 1'b0;

      // Note 10, three beats; the load comes on the very first edge after reset
      playEnable = 1'b1;
      applyStimulus(1'b1, 6'd10, 6'd3, 1'b0);
      checkOutput("t1PhaseReset", 32'(phaseReset), 1);
      checkOutput("t1BusyOnLoad", 32'(busy), 1);
      idleCycles(1);
      checkOutput("t1Step", 32'(stepSize), 2021);
      checkOutput("t1PhaseResetOff", 32'(phaseReset), 0);
      sampleTick = 1'b1;
      idleCycles(1);
      sampleTick = 1'b0;
      checkOutput("t1GenOn", 32'(generateNextSample), 1);
      idleCycles(1);
      checkOutput("t1GenOff", 32'(generateNextSample), 0);
      runBeats(2);
      checkOutput("t1NotDoneEarly", 32'(noteDone), 0);
      runBeats(1);
      checkOutput("t1Done", 32'(noteDone), 1);
      checkOutput("t1BusyDuringDone", 32'(busy), 1);
      idleCycles(1);
      checkOutput("t1DonePulse", 32'(noteDone), 0);
      checkOutput("t1BusyLow", 32'(busy), 0);
      idleCycles(3);
      checkOutput("t1DoneCount", 32'(ndCount), 1);

      // Rest note, two beats
      applyStimulus(1'b1, 6'd0, 6'd2, 1'b0);
      idleCycles(1);
      checkOutput("t2StepZero", 32'(stepSize), 0);
      sampleTick = 1'b1;
      idleCycles(1);
      sampleTick = 1'b0;
      checkOutput("t2Gen", 32'(generateNextSample), 1);
      runBeats(1);
      checkOutput("t2NotDoneEarly", 32'(noteDone), 0);
      runBeats(1);
      checkOutput("t2Done", 32'(noteDone), 1);
      idleCycles(1);
      checkOutput("t2DoneCount", 32'(ndCount), 2);

      // Zero duration finishes without a beat
      applyStimulus(1'b1, 6'd5, 6'd0, 1'b0);
      idleCycles(2);
      checkOutput("t3DoneNoBeat", 32'(noteDone), 1);
      checkOutput("t3Step", 32'(stepSize), 1514);
      idleCycles(1);
      checkOutput("t3DoneCount", 32'(ndCount), 3);
      checkOutput("t3BusyLow", 32'(busy), 0);

      // Pause for five beats after the first; resume together with a beat
      applyStimulus(1'b1, 6'd10, 6'd4, 1'b0);
      idleCycles(1);
      runBeats(1);
      playEnable = 1'b0;
      sampleTick = 1'b1;
      gnsSnap = gnsCount;
      runBeats(5);
      checkOutput("t4NoDonePaused", 32'(noteDone), 0);
      checkOutput("t4BusyPaused", 32'(busy), 1);
      checkOutput("t4NoGenPaused", 32'(gnsCount), 32'(gnsSnap));
      sampleTick = 1'b0;
      playEnable = 1'b1;
      applyStimulus(1'b0, 6'd0, 6'd0, 1'b1);
      runBeats(1);
      checkOutput("t4NotDoneEarly", 32'(noteDone), 0);
      runBeats(1);
      checkOutput("t4Done", 32'(noteDone), 1);
      idleCycles(1);
      checkOutput("t4DoneCount", 32'(ndCount), 4);

      // Second load while playing is ignored
      applyStimulus(1'b1, 6'd10, 6'd2, 1'b0);
      idleCycles(1);
      checkOutput("t5Step", 32'(stepSize), 2021);
      applyStimulus(1'b1, 6'd20, 6'd5, 1'b0);
      checkOutput("t5NoPhaseReset", 32'(phaseReset), 0);
      idleCycles(1);
      checkOutput("t5StepHeld", 32'(stepSize), 2021);
      runBeats(2);
      checkOutput("t5Done", 32'(noteDone), 1);
      idleCycles(4);
      checkOutput("t5DoneCount", 32'(ndCount), 5);
      checkOutput("t5BusyLow", 32'(busy), 0);
      checkOutput("t5StepIdle", 32'(stepSize), 2021);

      // Beat coinciding with the load is not counted
      applyStimulus(1'b1, 6'd20, 6'd2, 1'b1);
      idleCycles(1);
      checkOutput("t6Step", 32'(stepSize), 3600);
      runBeats(1);
      checkOutput("t6NotDoneEarly", 32'(noteDone), 0);
      runBeats(1);
      checkOutput("t6Done", 32'(noteDone), 1);
      idleCycles(1);

      // Asynchronous reset mid-note, then normal operation
      applyStimulus(1'b1, 6'd10, 6'd3, 1'b0);
      idleCycles(1);
      runBeats(1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("t7RstStep", 32'(stepSize), 0);
      checkOutput("t7RstBusy", 32'(busy), 0);
      checkOutput("t7RstGen", 32'(generateNextSample), 0);
      checkOutput("t7RstPhase", 32'(phaseReset), 0);
      checkOutput("t7RstDone", 32'(noteDone), 0);
      idleCycles(3);
      reset = 1'b0;
      checkOutput("t7NoDoneOnAbort", 32'(ndCount), 6);
      applyStimulus(1'b1, 6'd10, 6'd1, 1'b0);
      checkOutput("t7PhaseReset", 32'(phaseReset), 1);
      idleCycles(1);
      checkOutput("t7Step", 32'(stepSize), 2021);
      runBeats(1);
      checkOutput("t7Done", 32'(noteDone), 1);
      idleCycles(2);
      checkOutput("t7DoneCount", 32'(ndCount), 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have parameter NOTE_W, default 6, width of note number.
REQ-002 SHALL have parameter DUR_W, default 6, width of duration in beat ticks.
REQ-003 SHALL have parameter STEP_W, default 20, width of phase step to sine_reader.
REQ-004 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 SHALL have ports: play_enable  in  1  high = play; low = pause.
REQ-007 SHALL have ports: note_to_load  in  NOTE_W  note number; 0 = rest.
REQ-008 SHALL have ports: duration_to_load  in  DUR_W  note length in beat ticks.
REQ-009 SHALL have ports: load_new_note  in  1  single-cycle request to start a note.
REQ-010 SHALL have ports: beat  in  1  single-cycle duration tick.
REQ-011 SHALL have ports: sample_tick  in  1  single-cycle codec sample request.
REQ-012 SHALL have ports: step_size  out  STEP_W  phase increment to sine_reader.
REQ-013 SHALL have ports: generate_next_sample  out  1  gated sample strobe to sine_reader.
REQ-014 SHALL have ports: phase_reset  out  1  one-cycle pulse clearing sine_reader phase.
REQ-015 SHALL have ports: busy  out  1  high from note acceptance until note_done.
REQ-016 SHALL have ports: note_done  out  1  one-cycle pulse at end of note.

Function
REQ-017 SHALL instantiate frequency_rom (addr NOTE_W, dout STEP_W, one-cycle synchronous read) and apply note_to_load as its address.
REQ-018 SHALL implement FSM states IDLE, FETCH, PLAY, DONE.
REQ-019 IDLE: load_new_note high -> latch note and duration, assert busy, pulse phase_reset, go FETCH.
REQ-020 FETCH: exactly one cycle; register ROM output into step_size, or 0 if latched note = 0; go PLAY.
REQ-021 PLAY: on beat with play_enable high, decrement duration counter; on decrement from 1 -> 0, go DONE.
REQ-022 PLAY with latched duration 0: go DONE on the first cycle in PLAY, with no beat required.
REQ-023 DONE: pulse note_done for exactly one cycle, deassert busy, go IDLE.
REQ-024 step_size SHALL hold its value through DONE and IDLE until the next FETCH.
REQ-025 load_new_note SHALL be ignored in FETCH, PLAY and DONE; no queuing.
REQ-026 generate_next_sample = sample_tick AND play_enable AND state == PLAY, registered with one-cycle latency.
REQ-027 play_enable low SHALL freeze the duration counter and suppress generate_next_sample; beats arriving while low are lost.
REQ-028 Simultaneous beat and play_enable rise: the beat SHALL count.
REQ-029 Duration counter SHALL never wrap below 0.
REQ-030 Simultaneous beat and load_new_note in IDLE: the load is accepted; the beat is not counted against the new note.

Reset
REQ-031 Asserting reset SHALL force, asynchronously: state IDLE, step_size 0, generate_next_sample 0, phase_reset 0, busy 0, note_done 0, counter 0, latched note 0.
REQ-032 Reset mid-note SHALL abort the note without a note_done pulse.
REQ-033 The first edge after reset deasserts SHALL evaluate IDLE normally.

Verification
REQ-034 Reset, load note=10 dur=3, play_enable=1, beat every 8 cycles -> phase_reset 1 cycle after load; step_size = ROM[10] after FETCH; note_done exactly once after 3rd beat; busy low the next cycle.
REQ-035 Load note=0 dur=2 -> step_size = 0; generate_next_sample still follows sample_tick; note_done after 2 beats.
REQ-036 Load dur=0 -> note_done within 3 cycles of load, with no beat required.
REQ-037 Load dur=4, drop play_enable after 1 beat for 5 beats, then raise it -> no generate_next_sample while low; note_done after 3 further beats.
REQ-038 Second load_new_note during PLAY with note=20 -> ignored; step_size unchanged; single note_done.
REQ-039 Assert reset mid-PLAY (counter=2) -> all outputs 0 immediately, no note_done; subsequent load operates normally.
